// File: rtl/msdap_output_serializer.sv
// rtl/msdap_output_serializer.sv - serializes 40-bit L/R results MSB-first with a one-deep pending buffer
module msdap_output_serializer #(
    parameter int WIDTH = 40
) (
    input  logic             Sclk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             compute_done,
    input  logic [WIDTH-1:0] data_L,
    input  logic [WIDTH-1:0] data_R,
    output logic             OutputL,
    output logic             OutputR,
    output logic             OutReady,
    output logic             pending,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shl_q, shl_d, shr_q, shr_d;
    logic [WIDTH-1:0] pdl_q, pdl_d, pdr_q, pdr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             outready_q, outready_d;
    logic             outl_q, outl_d, outr_q, outr_d;

    always_comb begin
        state_d    = state_q;
        shl_d      = shl_q;
        shr_d      = shr_q;
        pdl_d      = pdl_q;
        pdr_d      = pdr_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        outready_d = outready_q;

        case (state_q)
            IDLE: begin
                if (compute_done) begin
                    shl_d      = data_L;
                    shr_d      = data_R;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                    outready_d = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d = '0;
                    if (pending_q) begin
                        // Queued word goes out with no gap; a same-cycle strobe refills the buffer.
                        shl_d = pdl_q;
                        shr_d = pdr_q;
                        if (compute_done) begin
                            pdl_d = data_L;
                            pdr_d = data_R;
                        end else begin
                            pending_d = 1'b0;
                        end
                    end else if (compute_done) begin
                        shl_d = data_L;
                        shr_d = data_R;
                    end else begin
                        state_d    = IDLE;
                        outready_d = 1'b0;
                    end
                end else begin
                    shl_d = {shl_q[WIDTH-2:0], 1'b0};
                    shr_d = {shr_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                    if (compute_done) begin
                        if (!pending_q) begin
                            pdl_d     = data_L;
                            pdr_d     = data_R;
                            pending_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        outl_d = outready_d & shl_d[WIDTH-1];
        outr_d = outready_d & shr_d[WIDTH-1];
    end

    always_ff @(posedge Sclk) begin
        if (Reset || Start) begin
            state_q    <= IDLE;
            shl_q      <= '0;
            shr_q      <= '0;
            pdl_q      <= '0;
            pdr_q      <= '0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            outready_q <= 1'b0;
            outl_q     <= 1'b0;
            outr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shl_q      <= shl_d;
            shr_q      <= shr_d;
            pdl_q      <= pdl_d;
            pdr_q      <= pdr_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            outready_q <= outready_d;
            outl_q     <= outl_d;
            outr_q     <= outr_d;
        end
    end

    assign OutputL  = outl_q;
    assign OutputR  = outr_q;
    assign OutReady = outready_q;
    assign pending  = pending_q;
    assign overrun  = overrun_q;

endmodule
